// File: rtl/ad_pkg.sv
// Shared constants and state encoding for the A/D capture drain path (ad_unpack).
package ad_pkg;

  localparam int AD_WORD_W         = 128;
  localparam int AD_BYTE_W         = 8;
  localparam int AD_BYTES_PER_WORD = AD_WORD_W / AD_BYTE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } ad_state_e;

endpackage

// File: rtl/ad_byte_shifter.sv
// Holds one packed FIFO word and presents it MSB byte first, tracking the byte index.
module ad_byte_shifter
  import ad_pkg::*;
#(
  parameter int WORD_W = AD_WORD_W,
  parameter int BYTE_W = AD_BYTE_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  output logic [BYTE_W-1:0] byte_out,
  output logic              last
);

  localparam int N     = WORD_W / BYTE_W;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;

  // Load wins over shift; the index wraps naturally after the final byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= load_data;
      idx   <= '0;
    end else if (shift) begin
      shreg <= shreg << BYTE_W;
      idx   <= idx + IDX_W'(1);
    end
  end

  assign byte_out = shreg[WORD_W-1 -: BYTE_W];
  assign last     = (idx == LAST_IDX);

endmodule

// File: rtl/ad_unpack.sv
// Drains 128-bit packed sample words from the capture FIFO into a valid/ready byte stream.
// Build option AD_UNPACK_STATS_EN adds word_count and stall_count outputs.
module ad_unpack
  import ad_pkg::*;
#(
  parameter int WORD_W = AD_WORD_W,
  parameter int BYTE_W = AD_BYTE_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
`ifdef AD_UNPACK_STATS_EN
  ,
  output logic [31:0]       word_count,
  output logic [31:0]       stall_count
`endif
);

  ad_state_e   state;
  ad_state_e   state_nxt;
  logic        load;
  logic        hs;
  logic        sh_last;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // fifo_rd_en is decoded only in IDLE, so at most one word is ever in flight.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    load       = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) state_nxt = FETCH;
      end
      FETCH: begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        out_valid = 1'b1;
        if (out_ready && sh_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign hs       = out_valid && out_ready;
  assign out_last = (state == SHIFT) && sh_last;
  assign busy     = (state != IDLE);

  ad_byte_shifter #(
    .WORD_W (WORD_W),
    .BYTE_W (BYTE_W)
  ) u_shifter (
    .CLK       (CLK),
    .RST       (RST),
    .load      (load),
    .shift     (hs),
    .load_data (fifo_dout),
    .byte_out  (out_data),
    .last      (sh_last)
  );

`ifdef AD_UNPACK_STATS_EN
  // Free-running counters; they wrap rather than saturate.
  always_ff @(posedge CLK) begin
    if (RST) begin
      word_count  <= '0;
      stall_count <= '0;
    end else begin
      if (hs && sh_last)           word_count  <= word_count + 32'd1;
      if (out_valid && !out_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ad_unpack.sv
// Directed bench for ad_unpack with a small non-FWFT FIFO model feeding it.
module tb_ad_unpack;

  logic         CLK = 1'b0;
  logic         RST;
  logic [127:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
`ifdef AD_UNPACK_STATS_EN
  logic [31:0]  word_count;
  logic [31:0]  stall_count;
`endif

  int vectors = 0;
  int fails   = 0;

  logic [127:0] fifo_mem [0:15];
  int           push_cnt = 0;
  int           rd_cnt   = 0;

  always #5 CLK = ~CLK;

  assign fifo_empty = (push_cnt == rd_cnt);

  always @(posedge CLK) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fifo_mem[rd_cnt];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  ad_unpack dut (
    .CLK        (CLK),
    .RST        (RST),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
`ifdef AD_UNPACK_STATS_EN
    ,
    .word_count (word_count),
    .stall_count(stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [127:0] w);
    fifo_mem[push_cnt] = w;
    push_cnt = push_cnt + 1;
  endtask

  // Waits for the first byte, then collects nbytes of word w.
  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1,0,0...
  task automatic run_word(input string tag, input logic [127:0] w, input int nbytes,
                          input int mode, output int gap);
    int k;
    int c;
    gap = 0;
    if (mode == 0) out_ready = 1'b1;
    while (!out_valid && gap < 8) begin
      gap++;
      @(negedge CLK);
    end
    if (!out_valid) begin
      chk({tag, "_start_timeout"}, out_valid, 1'b1);
      return;
    end
    k = 0;
    c = 0;
    while (k < nbytes && c < 80) begin
      if (mode == 1) out_ready = ((c % 3) == 0);
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_data"},  out_data,  w[127 - 8*k -: 8]);
      chk({tag, "_last"},  out_last,  (k == 15));
      chk({tag, "_busy"},  busy,      1'b1);
      chk({tag, "_rden"},  fifo_rd_en, 1'b0);
      if (out_ready) k++;
      c++;
      @(negedge CLK);
    end
    if (k < nbytes) chk({tag, "_byte_timeout"}, k, nbytes);
  endtask

  localparam logic [127:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] W1 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [127:0] W2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] W3 = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  localparam logic [127:0] W4 = 128'h5A5A5A5A_C3C3C3C3_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] W5 = 128'h10203040_50607080_90A0B0C0_D0E0F001;
  localparam logic [127:0] W6 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

  initial begin
    int gap;
    RST       = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_rden",  fifo_rd_en, 1'b0);
    chk("rst_valid", out_valid,  1'b0);
    chk("rst_last",  out_last,   1'b0);
    chk("rst_busy",  busy,       1'b0);
`ifdef AD_UNPACK_STATS_EN
    chk("rst_wcnt", word_count,  32'd0);
    chk("rst_scnt", stall_count, 32'd0);
`endif
    RST = 1'b0;
    @(negedge CLK);

    // Single word
    push(W0);
    #1;
    chk("w0_rden_now", fifo_rd_en, 1'b1);
    run_word("w0", W0, 16, 0, gap);
    chk("w0_gap", gap, 2);
    chk("w0_idle_valid", out_valid, 1'b0);
    chk("w0_idle_busy",  busy,      1'b0);
    chk("w0_rd_pulses",  rd_cnt,    1);
`ifdef AD_UNPACK_STATS_EN
    chk("w0_wcnt", word_count, 32'd1);
`endif

    // Back-to-back
    push(W1);
    push(W2);
    run_word("b2b0", W1, 16, 0, gap);
    chk("b2b0_gap", gap, 2);
    run_word("b2b1", W2, 16, 0, gap);
    chk("b2b1_gap", gap, 2);
    chk("b2b_rd_pulses", rd_cnt, 3);
`ifdef AD_UNPACK_STATS_EN
    chk("b2b_wcnt", word_count,  32'd3);
    chk("b2b_scnt", stall_count, 32'd0);
`endif

    // Backpressure: 16 bytes over 46 cycles, 30 stalled cycles
    push(W3);
    run_word("bp", W3, 16, 1, gap);
    chk("bp_gap", gap, 2);
    chk("bp_idle_valid", out_valid, 1'b0);
`ifdef AD_UNPACK_STATS_EN
    chk("bp_scnt", stall_count, 32'd30);
    chk("bp_wcnt", word_count,  32'd4);
`endif

    // Empty FIFO for 50 cycles
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      chk("empty_rden",  fifo_rd_en, 1'b0);
      chk("empty_valid", out_valid,  1'b0);
      chk("empty_busy",  busy,       1'b0);
      @(negedge CLK);
    end
    push(W4);
    #1;
    chk("empty_fall_rden", fifo_rd_en, 1'b1);
    run_word("ef", W4, 16, 0, gap);
    chk("ef_gap", gap, 2);

    // Reset after byte 5 of W5 is accepted
    push(W5);
    push(W6);
    run_word("mid", W5, 6, 0, gap);
    chk("mid_byte6", out_data, 8'h70);
    out_ready = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy",  busy,      1'b0);
    chk("mid_rst_last",  out_last,  1'b0);
`ifdef AD_UNPACK_STATS_EN
    chk("mid_rst_wcnt", word_count,  32'd0);
    chk("mid_rst_scnt", stall_count, 32'd0);
`endif
    RST = 1'b0;
    run_word("after_rst", W6, 16, 0, gap);
    chk("after_rst_gap", gap, 2);
    chk("after_rst_rd_pulses", rd_cnt, 7);
`ifdef AD_UNPACK_STATS_EN
    chk("after_rst_wcnt", word_count, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ad_unpack.md
# ad_unpack

Downstream drain stage for the A/D capture path. It reads 128-bit packed sample words from the capture FIFO that the packer fills, and serializes each word into a byte stream with a valid/ready handshake for the host link transmitter. Bytes leave in packing order: the oldest sample pair first, and within a pair the first channel byte first.

## Interface
- Parameters:
- WORD_W, 128, width of one FIFO word; must be an integer multiple of BYTE_W.
- BYTE_W, 8, width of one output byte.
- Ports:
- CLK  input  1  single clock for the whole block.
- RST  input  1  synchronous, active-high reset.
- fifo_dout  input  WORD_W  FIFO read data; valid the cycle after fifo_rd_en (standard, non-FWFT FIFO).
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read strobe, one cycle per word.
- out_data  output  BYTE_W  current byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the byte when out_valid and out_ready are both high.
- out_last  output  1  high together with out_valid on the final byte of a word.
- busy  output  1  high in any state other than IDLE.

## Operation
- N = WORD_W/BYTE_W bytes per word, which is 16 at the defaults. The byte index is log2(N) bits wide and wraps naturally.
- State machine: IDLE, FETCH, SHIFT.
- IDLE:
  - fifo_rd_en = !fifo_empty, decoded combinationally from the state.
  - If !fifo_empty, go to FETCH. Otherwise stay in IDLE.
- FETCH:
  - Load fifo_dout into a WORD_W shift register.
  - Clear the byte index to 0 and go to SHIFT.
  - fifo_rd_en = 0.
- SHIFT:
  - out_valid = 1 and out_data = shift register MSB byte [WORD_W-1 -: BYTE_W].
  - On a handshake, shift the register left by BYTE_W (zero fill) and increment the index.
  - When a handshake occurs at index N-1, go to IDLE.
- out_last = (state == SHIFT) && (index == N-1).
- fifo_rd_en is never asserted while fifo_empty = 1, and never outside IDLE. At most one word is in flight.
- While out_valid = 1 and out_ready = 0, out_data, out_last and the index hold stable.
- out_ready is ignored outside SHIFT.
- Reset values: state IDLE, fifo_rd_en 0, out_valid 0, out_last 0, busy 0, index 0, shift register 0.
- Reset mid-word: the partially sent word is discarded and no byte is replayed. The next word is read fresh.
- fifo_empty rising while in FETCH or SHIFT has no effect: the word has already been read.

## Timing
- fifo_empty is low in IDLE at cycle t:
  - fifo_rd_en = 1 at t.
  - FETCH at t+1.
  - First out_valid at t+2.
- With out_ready held high, one byte leaves per cycle, from t+2 to t+N+1.
- The final handshake at cycle u returns the block to IDLE at u+1, where the next fifo_rd_en can issue.
- Sustained throughput is N bytes per N+2 cycles.
- Latency from fifo_rd_en to the first byte is 2 cycles.

## Configuration
- Macro: AD_UNPACK_STATS_EN.
- Defined:
  - Adds output word_count (32 bits): number of words fully sent, incremented at the handshake on the last byte.
  - Adds output stall_count (32 bits): cycles with out_valid && !out_ready.
  - Both counters reset to 0 on RST, wrap modulo 2^32, and never saturate.
- Undefined: both ports and both counters are absent, and all other behaviour is identical.

## Structure
- Package ad_pkg holds:
  - constants AD_WORD_W = 128, AD_BYTE_W = 8, AD_BYTES_PER_WORD = 16;
  - the state enum (IDLE, FETCH, SHIFT).
- One sub-module is natural: ad_byte_shifter. It holds the shift register and byte index, with ports load, shift, load data, byte out and last. The state machine and FIFO/handshake control stay in ad_unpack.

## Test plan
- Single word: fifo_dout = 128'h00112233_44556677_8899AABB_CCDDEEFF, out_ready held 1.
  - Bytes 00,11,…,FF arrive on consecutive cycles.
  - out_last is high only on FF.
  - fifo_rd_en pulses exactly once.
- Back-to-back: two words queued, out_ready held 1.
  - Exactly 2 idle cycles between byte 15 of word 0 and byte 0 of word 1.
  - 32 bytes total, in order.
- Backpressure: out_ready toggles 1,0,0,1,… across one word.
  - out_data holds stable while stalled.
  - All 16 bytes arrive exactly once.
  - With AD_UNPACK_STATS_EN, stall_count equals the number of stalled cycles.
- Empty FIFO: fifo_empty = 1 for 50 cycles.
  - fifo_rd_en, out_valid and busy stay 0.
  - Then fifo_empty falls: fifo_rd_en asserts that same cycle.
- Reset mid-word: RST asserted after byte 5 is accepted.
  - Next cycle: out_valid = 0 and state is IDLE.
  - The next word restarts at its byte 0.
  - With stats enabled, word_count = 0.
